// File: rtl/lsu_sequencer.sv
// Load/store sequencer in front of a one-word-per-access big-endian data memory.
// Ports: req_* (execute-stage request), resp_* (completion), mem_* (data_memory side).
module lsu_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_writeData,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_dataRead,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_dataRead
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, WR, RESP
  } state_t;

  state_t              state;
  logic                half_sel;
  logic                wr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [31:0]         hi_q;

  logic                misal;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W-1:0]   addr_lo;
  logic [31:0]         rd_word;
  logic [7:0]          lane8;
  logic [15:0]         lane16;
  logic [31:0]         byte_m;
  logic [31:0]         half_m;
  logic [31:0]         merged;
  logic [63:0]         load_ext;
  logic                sx;
  logic                unused_hi;

  assign req_ready = (state == IDLE) & ~rst;
  assign word_addr = {req_address[ADDR_W-1:2], 2'b00};
  assign addr_lo   = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
  assign rd_word   = mem_dataRead[31:0];
  assign unused_hi = ^mem_dataRead[DATA_W-1:32];
  assign sx        = ~uns_q;

  always_comb begin
    misal = 1'b0;
    unique case (req_size)
      2'b01:   misal = req_address[0];
      2'b10:   misal = |req_address[1:0];
      2'b11:   misal = |req_address[2:0];
      default: misal = 1'b0;
    endcase
  end

  // Lane pick for loads and lane replace for sub-word stores.
  always_comb begin
    lane8  = 8'h0;
    byte_m = rd_word;
    half_m = rd_word;
    unique case (addr_q[1:0])
      2'd0: begin lane8 = rd_word[31:24]; byte_m[31:24] = wdata_q[7:0]; end
      2'd1: begin lane8 = rd_word[23:16]; byte_m[23:16] = wdata_q[7:0]; end
      2'd2: begin lane8 = rd_word[15:8];  byte_m[15:8]  = wdata_q[7:0]; end
      default: begin lane8 = rd_word[7:0]; byte_m[7:0] = wdata_q[7:0]; end
    endcase
    if (addr_q[1]) begin
      lane16       = rd_word[15:0];
      half_m[15:0] = wdata_q[15:0];
    end else begin
      lane16        = rd_word[31:16];
      half_m[31:16] = wdata_q[15:0];
    end
    unique case (size_q)
      2'b00: begin
        load_ext = {{56{sx & lane8[7]}}, lane8};
        merged   = byte_m;
      end
      2'b01: begin
        load_ext = {{48{sx & lane16[15]}}, lane16};
        merged   = half_m;
      end
      default: begin
        load_ext = {{32{sx & rd_word[31]}}, rd_word};
        merged   = rd_word;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      half_sel      <= 1'b0;
      wr_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      hi_q          <= '0;
      resp_valid    <= 1'b0;
      resp_dataRead <= '0;
      resp_error    <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_memRead   <= 1'b0;
      mem_memWrite  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            addr_q   <= req_address;
            wdata_q  <= req_writeData;
            half_sel <= 1'b0;
            if (misal) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_error    <= 1'b1;
              resp_dataRead <= '0;
            end else if (req_write && req_size[1]) begin
              // Word and double stores need no read; double starts hi.
              state        <= WR;
              mem_memWrite <= 1'b1;
              mem_address  <= word_addr;
              mem_writeData <= req_size[0]
                ? DATA_W'(req_writeData[63:32])
                : DATA_W'(req_writeData[31:0]);
            end else begin
              state       <= RD_A;
              mem_memRead <= 1'b1;
              mem_address <= word_addr;
            end
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          if (wr_q) begin
            state         <= WR;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b1;
            mem_writeData <= DATA_W'(merged);
          end else if (size_q == 2'b11 && !half_sel) begin
            hi_q        <= rd_word;
            half_sel    <= 1'b1;
            mem_address <= addr_lo;
            state       <= RD_A;
          end else begin
            mem_memRead <= 1'b0;
            mem_address <= '0;
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_dataRead <= (size_q == 2'b11)
              ? DATA_W'({hi_q, rd_word})
              : DATA_W'(load_ext);
          end
        end
        WR: begin
          if (size_q == 2'b11 && !half_sel) begin
            half_sel      <= 1'b1;
            mem_address   <= addr_lo;
            mem_writeData <= DATA_W'(wdata_q[31:0]);
          end else begin
            mem_memWrite  <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_dataRead <= '0;
          end
        end
        RESP: begin
          state         <= IDLE;
          half_sel      <= 1'b0;
          resp_valid    <= 1'b0;
          resp_error    <= 1'b0;
          resp_dataRead <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a dual-edge word memory model.
// Table-driven requests plus hand-written multi-cycle sequences.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_address;
  logic [63:0] req_writeData;
  logic        resp_valid;
  logic [63:0] resp_dataRead;
  logic        resp_error;
  logic [9:0]  mem_address;
  logic [63:0] mem_writeData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [63:0] mem_dataRead = '0;

  lsu_sequencer #(.ADDR_W(10), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_address(req_address),
    .req_writeData(req_writeData),
    .resp_valid(resp_valid), .resp_dataRead(resp_dataRead),
    .resp_error(resp_error),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_dataRead(mem_dataRead)
  );

  always #5 clk = ~clk;

  // Memory model: acts on both clock edges, big-endian words.
  logic [7:0] mem [0:1023];
  always @(posedge clk or negedge clk) begin
    int a;
    a = int'(mem_address);
    if (mem_memWrite) begin
      mem[a]   = mem_writeData[31:24];
      mem[a+1] = mem_writeData[23:16];
      mem[a+2] = mem_writeData[15:8];
      mem[a+3] = mem_writeData[7:0];
    end
    if (mem_memRead)
      mem_dataRead <= {32'h0, mem[a], mem[a+1], mem[a+2], mem[a+3]};
  end

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  int both_cnt = 0;
  int unal_cnt = 0;
  int strobe_cnt = 0;
  always @(negedge clk) begin
    if (mem_memRead && mem_memWrite) both_cnt++;
    if ((mem_memRead || mem_memWrite) && mem_address[1:0] != 2'b00) unal_cnt++;
    if (mem_memRead || mem_memWrite) strobe_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [9:0]  addr;
    logic [63:0] wd;
    logic [63:0] exp_d;
    logic        exp_e;
    int          lat;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [9:0] a, input logic [63:0] wd,
                              input logic [63:0] ed, input logic ee, input int lat);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.exp_d = ed; v.exp_e = ee; v.lat = lat;
    tv.push_back(v);
  endfunction

  // Caller is at posedge+1 with the DUT idle.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_address = a; req_writeData = wd;
    chk("ready_at_issue", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input vec_t v, output int lat, output logic [63:0] d, output logic e);
    lat = 0; d = '0; e = 1'b0;
    issue(v.wr, v.sz, v.uns, v.addr, v.wd);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; d = resp_dataRead; e = resp_error;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  logic        tr_rd [1:6];
  logic        tr_wr [1:6];
  logic        tr_rv [1:6];
  logic [9:0]  tr_a  [1:6];
  logic [63:0] tr_wd [1:6];

  task automatic trace(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr_rd[k] = mem_memRead; tr_wr[k] = mem_memWrite;
      tr_rv[k] = resp_valid;  tr_a[k]  = mem_address;
      tr_wd[k] = mem_writeData;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [63:0] d;
    logic e;
    int sc;

    add(1, 2'd3, 0, 10'h008, 64'h0123456789ABCDEF, 64'h0, 0, 3);
    add(0, 2'd3, 0, 10'h008, 64'h0, 64'h0123456789ABCDEF, 0, 5);
    add(0, 2'd2, 0, 10'h00C, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 3);
    add(0, 2'd2, 1, 10'h00C, 64'h0, 64'h0000000089ABCDEF, 0, 3);
    add(1, 2'd2, 0, 10'h010, 64'h11223344, 64'h0, 0, 2);
    add(1, 2'd0, 0, 10'h012, 64'hAA, 64'h0, 0, 4);
    add(0, 2'd2, 0, 10'h010, 64'h0, 64'h000000001122AA44, 0, 3);
    add(0, 2'd0, 0, 10'h012, 64'h0, 64'hFFFFFFFFFFFFFFAA, 0, 3);
    add(0, 2'd0, 1, 10'h012, 64'h0, 64'h00000000000000AA, 0, 3);
    add(0, 2'd1, 0, 10'h010, 64'h0, 64'h0000000000001122, 0, 3);
    add(1, 2'd1, 0, 10'h012, 64'h8001, 64'h0, 0, 4);
    add(0, 2'd1, 0, 10'h012, 64'h0, 64'hFFFFFFFFFFFF8001, 0, 3);
    add(0, 2'd0, 1, 10'h013, 64'h0, 64'h0000000000000001, 0, 3);
    add(0, 2'd0, 0, 10'h010, 64'h0, 64'h0000000000000011, 0, 3);
    add(1, 2'd0, 0, 10'h011, 64'hFFFFFFFFFFFFFF55, 64'h0, 0, 4);
    add(0, 2'd2, 0, 10'h010, 64'h0, 64'h0000000011558001, 0, 3);
    add(0, 2'd2, 0, 10'h011, 64'h0, 64'h0, 1, 1);
    add(0, 2'd3, 0, 10'h00C, 64'h0, 64'h0, 1, 1);
    add(0, 2'd1, 0, 10'h013, 64'h0, 64'h0, 1, 1);
    add(1, 2'd1, 0, 10'h001, 64'h1234, 64'h0, 1, 1);
    add(1, 2'd3, 0, 10'h3F8, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 3);
    add(0, 2'd3, 0, 10'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 5);
    add(0, 2'd2, 1, 10'h3FC, 64'h0, 64'h00000000CAFEF00D, 0, 3);

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_address = '0; req_writeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        {55'h0, req_ready, resp_valid, resp_error, mem_memRead, mem_memWrite,
         |resp_dataRead, |mem_address, |mem_writeData}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      sc = strobe_cnt;
      do_req(tv[i], lat, d, e);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_data", i), d, tv[i].exp_d);
      chk($sformatf("v%0d_err", i), {63'h0, e}, {63'h0, tv[i].exp_e});
      if (tv[i].exp_e)
        chk($sformatf("v%0d_no_strobe", i), 64'(strobe_cnt - sc), 64'h0);
    end

    chk("mem_008", {32'h0, rd_word(8)},  64'h01234567);
    chk("mem_00C", {32'h0, rd_word(12)}, 64'h89ABCDEF);

    // Byte store RMW trace: read, read, write merged, respond.
    issue(1'b1, 2'd0, 1'b0, 10'h010, 64'h99);
    trace(4);
    chk("rmw_c1_rd", {62'h0, tr_rd[1], tr_wr[1]}, 64'h2);
    chk("rmw_c1_addr", 64'(tr_a[1]), 64'h010);
    chk("rmw_c2_rd", {62'h0, tr_rd[2], tr_wr[2]}, 64'h2);
    chk("rmw_c3_wr", {62'h0, tr_rd[3], tr_wr[3]}, 64'h1);
    chk("rmw_c3_addr", 64'(tr_a[3]), 64'h010);
    chk("rmw_c3_data", tr_wd[3], 64'h0000000099558001);
    chk("rmw_c4_resp", {62'h0, tr_rv[4], tr_wr[4]}, 64'h2);

    // Double store write order: hi word then lo word.
    issue(1'b1, 2'd3, 1'b0, 10'h100, 64'hA1A2A3A4B1B2B3B4);
    trace(3);
    chk("ds_c1", {tr_wd[1][31:0], 21'h0, tr_wr[1], tr_a[1]}, {32'hA1A2A3A4, 21'h0, 1'b1, 10'h100});
    chk("ds_c2", {tr_wd[2][31:0], 21'h0, tr_wr[2], tr_a[2]}, {32'hB1B2B3B4, 21'h0, 1'b1, 10'h104});
    chk("ds_c3_resp", {62'h0, tr_rv[3], tr_wr[3]}, 64'h2);

    // Back-to-back word stores with req_valid held high.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_address = 10'h020; req_writeData = 64'h00000000CAFEBABE;
    @(posedge clk); #1;
    req_address = 10'h024; req_writeData = 64'h0000000012345678;
    @(negedge clk);
    chk("b2b_t1", {61'h0, req_ready, mem_memWrite, resp_valid}, 64'h2);
    chk("b2b_t1_addr", 64'(mem_address), 64'h020);
    @(negedge clk);
    chk("b2b_t2", {61'h0, req_ready, mem_memWrite, resp_valid}, 64'h1);
    @(negedge clk);
    chk("b2b_t3", {61'h0, req_ready, mem_memWrite, resp_valid}, 64'h4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_t4", {mem_writeData[31:0], 21'h0, mem_memWrite, mem_address},
        {32'h12345678, 21'h0, 1'b1, 10'h024});
    @(negedge clk);
    chk("b2b_t5_resp", {63'h0, resp_valid}, 64'h1);
    @(posedge clk); #1;
    chk("mem_020", {32'h0, rd_word(32)}, 64'hCAFEBABE);
    chk("mem_024", {32'h0, rd_word(36)}, 64'h12345678);

    // Reset during the second RD_A of a double load.
    issue(1'b0, 2'd3, 1'b0, 10'h008, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rd_a2", {62'h0, mem_memRead, resp_valid, 2'b00} | 64'(mem_address) << 4,
        (64'h00C << 4) | 64'h8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outputs",
        {56'h0, req_ready, resp_valid, resp_error, mem_memRead, mem_memWrite,
         |resp_dataRead, |mem_address, |mem_writeData}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {62'h0, req_ready, resp_valid}, 64'h2);
    @(posedge clk); #1;

    chk("never_rd_and_wr", 64'(both_cnt), 64'h0);
    chk("mem_addr_aligned", 64'(unal_cnt), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
Load/store sequencer directly upstream of data_memory: sole driver of its port set (data_address, writeData, memRead, memWrite).
- Accepts one load/store request per handshake from the execute stage.
- Data memory moves exactly one big-endian 32-bit word per access (bytes addr..addr+3, byte at addr in bits 31:24).
- The sequencer splits doubleword accesses into two word accesses, does read-modify-write for byte/half stores, extracts and extends sub-word loads, and traps misaligned accesses.

Parameters:
ADDR_W, 10, byte-address width; must match data_memory.
DATA_W, 64, request/response data width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept; high only in IDLE.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 double.
req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend; ignored for double and stores.
req_address  input  ADDR_W  byte address.
req_writeData  input  DATA_W  store data, right-justified (byte uses [7:0], half [15:0], word [31:0]).
resp_valid  output  1  one-cycle completion pulse.
resp_dataRead  output  DATA_W  load result; 0 for stores and errors.
resp_error  output  1  misaligned access, valid with resp_valid.
mem_address  output  ADDR_W  to data_memory data_address; always word-aligned.
mem_writeData  output  DATA_W  to data_memory writeData; word in [31:0], [63:32]=0.
mem_memRead  output  1  to data_memory memRead.
mem_memWrite  output  1  to data_memory memWrite.
mem_dataRead  input  DATA_W  from data_memory dataRead; word in [31:0].

Behaviour:
- Reset: single clock, rst synchronous active-high. State IDLE; every output 0 except req_ready, which is 1 from the first cycle after rst deasserts.
- Reset mid-operation aborts immediately; no memory strobe in the following cycle. A double store aborted after its first write leaves the high word written (accepted).
- Accept: req_valid & req_ready at rising edge T latches all req_* fields; req_ready drops in T+1.
- Alignment rules: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0. Violation -> no memory access; resp_valid=1, resp_error=1, resp_dataRead=0 in T+1.
- Memory contract: data_memory updates on both clock edges.
  - Read: hold mem_memRead=1 at a fixed address for two cycles (RD_A issue, RD_B capture); sample mem_dataRead[31:0] at the end of RD_B.
  - Write: mem_memWrite=1 for exactly one cycle; the double-edge rewrite of identical data is harmless.
  - memRead and memWrite are never asserted together. Address and data are stable for the whole strobe.
- FSM states: IDLE, RD_A, RD_B, WR, RESP. A counter `half_sel` (0 = high word at addr, 1 = low word at addr+4) sequences doubles.
- Sequences and response cycle (accept at T):
  - byte/half/word load: RD_A, RD_B, RESP at T+3.
  - double load: RD_A, RD_B (hi), RD_A, RD_B (lo), RESP at T+5.
  - word store: WR, RESP at T+2.
  - double store: WR hi (addr, data[63:32]), WR lo (addr+4, data[31:0]), RESP at T+3.
  - byte/half store: RD_A, RD_B (aligned word addr & ~3), WR of the merged word, RESP at T+4.
- RESP lasts one cycle, then IDLE. Back-to-back requests are accepted in the cycle after RESP.
- Lane select: byte offset k=addr[1:0] uses word bits [31-8k -: 8]; half offset 0 uses [31:16], offset 2 uses [15:0].
- Store merge replaces only the selected lane with the low bits of req_writeData; other lanes keep the value read.
- Load extension to 64 bits: signed copies the lane MSB, unsigned fills zeros. Double result = {hi_word, lo_word}.
- Address arithmetic is ADDR_W bits. Aligned doubles end at most at 1023, so addr+4 never wraps.
- mem_* outputs are 0 in IDLE and RESP.

Test Plan:
1. Reset mid double load (rst high during 2nd RD_A) -> next cycle all mem_* = 0, resp_valid=0; req_ready=1 after rst low.
2. Double store 0x0123456789ABCDEF at 0x008, then double load at 0x008 -> two writes (0x008: 0x01234567, 0x00C: 0x89ABCDEF); load resp at T+5 = 0x0123456789ABCDEF.
3. Word 0x11223344 at 0x010; store byte 0xAA at 0x012 -> RMW writes 0x1122AA44 at T+3, resp at T+4; signed byte load 0x012 -> 0xFFFFFFFFFFFFFFAA; unsigned -> 0x00000000000000AA.
4. Half load at 0x010 signed -> 0x0000000000001122; store half 0x8001 at 0x012, signed half load 0x012 -> 0xFFFFFFFFFFFF8001.
5. Word load at 0x011, double at 0x00C, half at 0x013 -> each resp_error=1 at T+1; mem_memRead/mem_memWrite never assert.
6. req_valid held high for two back-to-back word stores -> req_ready low T+1..T+2; second accepted at T+3; no cycle with memRead & memWrite both high.
